dcache_cmo_handler: RTL and testbench
=====================================

# dcache_cmo_handler

Responder side of the CMO request/response interface, placed inside the L1 data cache. Accepts one `cmo_req_t` at a time from the CMO functional unit and executes it against the tag array and the writeback unit: clean, flush or invalidate one line or the whole cache. Answers each request with a one-cycle `ack` pulse carrying the request's `trans_id` on `cmo_resp_t`.

## Interface
- `NR_SETS`, 256: cache sets, power of 2. `IDX_W = $clog2(NR_SETS)`.
- `NR_WAYS`, 4: ways, power of 2. `WAY_W = $clog2(NR_WAYS)`.
- `LINE_OFF`, 4: byte-offset bits per line.
- `TAG_W`, 44: stored tag width. The tag is `address[LINE_OFF+IDX_W +: TAG_W]`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `cmo_req_i` in `cmo_req_t`: request. Fields are `req`, `trans_id`, `address`, `cmo_op`.
- `cmo_resp_o` out `cmo_resp_t`: response. Fields are `req_ready`, `ack`, `trans_id`.
- `arr_req_o` out 1: tag array access request.
- `arr_gnt_i` in 1: tag array grant, same cycle as the request.
- `arr_we_o` out 1: access type. 1 = invalidate (clear valid), 0 = read.
- `arr_index_o` out IDX_W: set index.
- `arr_way_mask_o` out NR_WAYS: ways to invalidate. Only meaningful when `arr_we_o`=1.
- `arr_rvalid_i` in 1: read data valid, one cycle after a granted read.
- `arr_valid_i` in NR_WAYS: per-way valid bits.
- `arr_dirty_i` in NR_WAYS: per-way dirty bits.
- `arr_tag_i` in NR_WAYS×TAG_W: per-way tags.
- `wb_req_o` out 1: request writeback of a line. The writeback unit also clears the line's dirty bit.
- `wb_gnt_i` in 1: writeback accepted.
- `wb_index_o` out IDX_W: writeback set.
- `wb_way_o` out WAY_W: writeback way.
- `wb_done_i` in 1: one-cycle pulse when the line is written back and its dirty bit is cleared.

## Operation
- **FSM states:** IDLE, LOOKUP, COMPARE, WB_REQ, WB_WAIT, INVAL, NEXT, ACK.
- **IDLE**
  - `req_ready`=1 only in IDLE.
  - On `req & req_ready`, register `trans_id`, `address` and `cmo_op`, and clear the set counter.
  - CLEAN, FLUSH, INVAL and the `_ALL` ops go to LOOKUP.
  - ZERO, PREFETCH_R, PREFETCH_W, PREFETCH_I and NONE go directly to ACK with no array activity. cbo.zero is executed by the store path.
- **LOOKUP**
  - Drive `arr_req_o`=1, `arr_we_o`=0.
  - Index is `address[LINE_OFF +: IDX_W]` for single-line ops, or the set counter for `_ALL` ops.
  - Hold until `arr_gnt_i`, then go to COMPARE.
- **COMPARE** (on `arr_rvalid_i`): build the target mask.
  - Single-line ops: `valid & (tag==addr_tag)`. At most one bit may be set; an assertion checks this.
  - `_ALL` ops: `valid`.
  - `dirty_mask = target & dirty` for CLEAN and FLUSH variants; 0 for INVAL variants.
  - If `dirty_mask` is nonzero, go to WB_REQ. Otherwise go to INVAL if the op is FLUSH/INVAL and `target` is nonzero. Otherwise go to NEXT.
- **WB_REQ**
  - Drive `wb_req_o` for the lowest set bit of `dirty_mask`; hold until `wb_gnt_i`.
  - Then go to WB_WAIT, which waits for `wb_done_i` and clears that bit.
  - If bits remain, return to WB_REQ. Otherwise go to INVAL (FLUSH variants with `target` nonzero) or NEXT.
- **INVAL**
  - Drive `arr_req_o`=1, `arr_we_o`=1, `arr_way_mask_o=target`.
  - On `arr_gnt_i`, go to NEXT.
- **NEXT**
  - Single-line op: go to ACK.
  - `_ALL` op: if the counter equals NR_SETS-1, go to ACK. Otherwise increment the counter (IDX_W wide) and go to LOOKUP.
- **ACK**
  - `ack`=1 with the registered `trans_id` for exactly one cycle, then return to IDLE.
- **Outputs outside their states:** `trans_id` output is 0 when `ack`=0. `arr_way_mask_o`=0 when `arr_we_o`=0.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, registers cleared. `req_ready` becomes 1 in the first cycle after reset deasserts.
- **Reset mid-operation:** drops the operation without an ack. Array and writeback requests deassert immediately.
- **Minimum latencies** (accept at cycle 0, grants immediate):
  - Miss or clean-nondirty hit: `ack` at cycle 4 (LOOKUP 1, COMPARE 2, NEXT 3, ACK 4).
  - INVAL hit: `ack` at cycle 5.
  - Clean of a dirty line: `ack` at cycle 6 + writeback latency.
- **Throughput:** a new request can be accepted the cycle after ACK. No back-to-back overlap.
- **Input stability:** `cmo_req_i` is sampled only on acceptance; changes afterwards are ignored.
- **Grant waits:** `arr_gnt_i`/`wb_gnt_i` may stay low indefinitely. Request outputs are held stable until granted.

## Configuration
- **`DCACHE_CMO_ALL_EN` defined:** `_ALL` ops walk every set as described.
- **Not defined:**
  - The set counter and the NEXT loop-back are removed.
  - CLEAN_ALL, FLUSH_ALL and INVAL_ALL go IDLE→ACK with no array activity; the decoder flags them illegal on such builds.

## Structure
- `cmo_t`, `cmo_req_t` and `cmo_resp_t` stay in `ariane_pkg`.
- Add helpers `cmo_is_all(cmo_t)` and `cmo_needs_wb(cmo_t)` to `ariane_pkg`.
- The FSM enum is local.
- No sub-module. Lowest-set-bit selection uses `lzc` from common_cells.

## Test plan
- **CLEAN, dirty hit:** `address=0x8000_1230`, way 2 valid+dirty with matching tag → one `wb_req` with index 0x23, way 2. `ack` after `wb_done`, `trans_id=5`. No invalidate.
- **INVAL, dirty hit:** way 1 dirty → no `wb_req`. Invalidate with mask 4'b0010, then `ack`.
- **FLUSH, miss:** no way valid → no `wb_req` and no invalidate. `ack` at cycle 4.
- **FLUSH_ALL:** sets 0 and 255 each have ways 0 and 3 dirty → 4 writebacks, 2 invalidates (mask 4'b1001). 256 lookups. Single `ack` (with and without `DCACHE_CMO_ALL_EN`).
- **Stalls:** `arr_gnt_i` low for 10 cycles, then reset asserted in WB_WAIT → outputs stable while stalled. After reset all outputs are 0 and `req_ready`=1.
- **PREFETCH_W:** `trans_id=7` → `ack` at cycle 1 with `trans_id` 7, no array access.

Source files
------------

// File: rtl/ariane_pkg.sv
// ariane_pkg: CMO request/response types shared by the CMO functional unit and the L1 data cache.
package ariane_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        CMO_CLEAN, CMO_FLUSH, CMO_INVAL, CMO_ZERO,
        CMO_PREFETCH_I, CMO_PREFETCH_R, CMO_PREFETCH_W,
        CMO_CLEAN_ALL, CMO_FLUSH_ALL, CMO_INVAL_ALL, CMO_NONE
    } cmo_t;

    typedef struct packed {
        logic                     req;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              address;
        cmo_t                     cmo_op;
    } cmo_req_t;

    typedef struct packed {
        logic                     req_ready;
        logic                     ack;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } cmo_resp_t;

    function automatic logic cmo_is_all(cmo_t op);
        return op inside {CMO_CLEAN_ALL, CMO_FLUSH_ALL, CMO_INVAL_ALL};
    endfunction

    function automatic logic cmo_needs_wb(cmo_t op);
        return op inside {CMO_CLEAN, CMO_FLUSH, CMO_CLEAN_ALL, CMO_FLUSH_ALL};
    endfunction
endpackage

// File: rtl/lzc.sv
// lzc: trailing (MODE=0) or leading (MODE=1) zero counter with the common_cells interface.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[MODE ? (WIDTH - 1 - i) : i]) cnt_o = CNT_WIDTH'(i);
        end
    end

    assign empty_o = ~|in_i;
endmodule

// File: rtl/dcache_cmo_handler.sv
// dcache_cmo_handler: executes clean/flush/invalidate CMOs against the L1D tag array and writeback unit.
// Define DCACHE_CMO_ALL_EN to let the _ALL ops walk every set; otherwise they are acked with no array activity.
module dcache_cmo_handler
    import ariane_pkg::*;
#(
    parameter int unsigned NR_SETS  = 256,
    parameter int unsigned NR_WAYS  = 4,
    parameter int unsigned LINE_OFF = 4,
    parameter int unsigned TAG_W    = 44,
    localparam int unsigned IDX_W   = $clog2(NR_SETS),
    localparam int unsigned WAY_W   = $clog2(NR_WAYS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  cmo_req_t                        cmo_req_i,
    output cmo_resp_t                       cmo_resp_o,
    output logic                            arr_req_o,
    input  logic                            arr_gnt_i,
    output logic                            arr_we_o,
    output logic [IDX_W-1:0]                arr_index_o,
    output logic [NR_WAYS-1:0]              arr_way_mask_o,
    input  logic                            arr_rvalid_i,
    input  logic [NR_WAYS-1:0]              arr_valid_i,
    input  logic [NR_WAYS-1:0]              arr_dirty_i,
    input  logic [NR_WAYS-1:0][TAG_W-1:0]   arr_tag_i,
    output logic                            wb_req_o,
    input  logic                            wb_gnt_i,
    output logic [IDX_W-1:0]                wb_index_o,
    output logic [WAY_W-1:0]                wb_way_o,
    input  logic                            wb_done_i
);
    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WB_REQ, WB_WAIT, INVAL, NEXT, ACK} state_t;

    state_t                   state_q, state_d;
    logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;
    cmo_t                     op_q, op_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [NR_WAYS-1:0]       target_q, target_d, dirty_q, dirty_d, hit;
    logic                     all_req, all_op, inval_op, unused_empty, unused_addr;

    assign unused_addr = ^{cmo_req_i.address[LINE_OFF-1:0], cmo_req_i.address[63:LINE_OFF+IDX_W+TAG_W]};
    assign inval_op    = op_q inside {CMO_FLUSH, CMO_INVAL, CMO_FLUSH_ALL, CMO_INVAL_ALL};

`ifdef DCACHE_CMO_ALL_EN
    logic [IDX_W-1:0] cnt_q, cnt_d;
    assign all_req     = cmo_is_all(cmo_req_i.cmo_op);
    assign all_op      = cmo_is_all(op_q);
    assign arr_index_o = all_op ? cnt_q : idx_q;
`else
    assign all_req     = 1'b0;
    assign all_op      = 1'b0;
    assign arr_index_o = idx_q;
`endif

    always_comb begin
        for (int w = 0; w < NR_WAYS; w++) hit[w] = arr_valid_i[w] && (arr_tag_i[w] == tag_q);
    end

    always_comb begin
        state_d    = state_q;
        trans_id_d = trans_id_q;
        op_d       = op_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        target_d   = target_q;
        dirty_d    = dirty_q;
`ifdef DCACHE_CMO_ALL_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: if (cmo_req_i.req) begin
                trans_id_d = cmo_req_i.trans_id;
                op_d       = cmo_req_i.cmo_op;
                idx_d      = cmo_req_i.address[LINE_OFF +: IDX_W];
                tag_d      = cmo_req_i.address[LINE_OFF+IDX_W +: TAG_W];
`ifdef DCACHE_CMO_ALL_EN
                cnt_d      = '0;
`endif
                state_d    = (cmo_req_i.cmo_op inside {CMO_CLEAN, CMO_FLUSH, CMO_INVAL} || all_req) ? LOOKUP : ACK;
            end
            LOOKUP: if (arr_gnt_i) state_d = COMPARE;
            COMPARE: if (arr_rvalid_i) begin
                target_d = all_op ? arr_valid_i : hit;
                dirty_d  = cmo_needs_wb(op_q) ? (target_d & arr_dirty_i) : '0;
                state_d  = (|dirty_d) ? WB_REQ : (inval_op && (|target_d)) ? INVAL : NEXT;
            end
            WB_REQ: if (wb_gnt_i) state_d = WB_WAIT;
            // dirty_q only holds ways of target, so target is known nonzero here
            WB_WAIT: if (wb_done_i) begin
                dirty_d[wb_way_o] = 1'b0;
                state_d           = (|dirty_d) ? WB_REQ : inval_op ? INVAL : NEXT;
            end
            INVAL: if (arr_gnt_i) state_d = NEXT;
`ifdef DCACHE_CMO_ALL_EN
            NEXT: begin
                state_d = (all_op && cnt_q != IDX_W'(NR_SETS - 1)) ? LOOKUP : ACK;
                cnt_d   = cnt_q + IDX_W'(1);
            end
`else
            NEXT: state_d = ACK;
`endif
            ACK: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            trans_id_q <= '0;
            op_q       <= CMO_CLEAN;
            idx_q      <= '0;
            tag_q      <= '0;
            target_q   <= '0;
            dirty_q    <= '0;
`ifdef DCACHE_CMO_ALL_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            trans_id_q <= trans_id_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            dirty_q    <= dirty_d;
`ifdef DCACHE_CMO_ALL_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    lzc #(.WIDTH(NR_WAYS), .MODE(1'b0)) i_lzc (
        .in_i   (dirty_q),
        .cnt_o  (wb_way_o),
        .empty_o(unused_empty)
    );

    assign cmo_resp_o.req_ready = rst_ni && (state_q == IDLE);
    assign cmo_resp_o.ack       = (state_q == ACK);
    assign cmo_resp_o.trans_id  = (state_q == ACK) ? trans_id_q : '0;
    assign arr_req_o            = (state_q == LOOKUP) || (state_q == INVAL);
    assign arr_we_o             = (state_q == INVAL);
    assign arr_way_mask_o       = (state_q == INVAL) ? target_q : '0;
    assign wb_req_o             = (state_q == WB_REQ);
    assign wb_index_o           = arr_index_o;

    // a single-line lookup can match at most one way
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == COMPARE && arr_rvalid_i && !all_op) |-> $onehot0(hit));
endmodule

// File: tb/tb_dcache_cmo_handler.sv
// tb_dcache_cmo_handler: directed tests of dcache_cmo_handler against a small tag-array and writeback model.
module tb_dcache_cmo_handler;
    import ariane_pkg::*;
    localparam int NR_SETS = 256, NR_WAYS = 4, TAG_W = 44, IDX_W = 8, WAY_W = 2;

    logic clk_i = 1'b0;
    logic rst_ni;
    cmo_req_t cmo_req_i;
    cmo_resp_t cmo_resp_o;
    logic arr_req_o, arr_gnt_i, arr_we_o, arr_rvalid_i;
    logic [IDX_W-1:0] arr_index_o, wb_index_o;
    logic [NR_WAYS-1:0] arr_way_mask_o, arr_valid_i, arr_dirty_i;
    logic [NR_WAYS-1:0][TAG_W-1:0] arr_tag_i;
    logic wb_req_o, wb_gnt_i, wb_done_i;
    logic [WAY_W-1:0] wb_way_o;

    int checks = 0, errors = 0;
    logic [NR_WAYS-1:0] val_m [NR_SETS];
    logic [NR_WAYS-1:0] dirty_m [NR_SETS];
    logic [NR_WAYS-1:0][TAG_W-1:0] tag_m [NR_SETS];
    int lk_cnt = 0, inv_cnt = 0, wb_cnt = 0, ack_cnt = 0;
    logic [NR_WAYS-1:0] inv_mask = '0;
    logic [IDX_W-1:0] wb_idx = '0;
    logic [WAY_W-1:0] wb_way = '0;
    logic wb_pend, wb_hold, gnt_en, wbg_en;

    assign arr_gnt_i = gnt_en;
    assign wb_gnt_i  = wbg_en;

    always #5 clk_i = ~clk_i;

    dcache_cmo_handler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmo_req_i(cmo_req_i), .cmo_resp_o(cmo_resp_o),
        .arr_req_o(arr_req_o), .arr_gnt_i(arr_gnt_i), .arr_we_o(arr_we_o), .arr_index_o(arr_index_o),
        .arr_way_mask_o(arr_way_mask_o), .arr_rvalid_i(arr_rvalid_i), .arr_valid_i(arr_valid_i),
        .arr_dirty_i(arr_dirty_i), .arr_tag_i(arr_tag_i), .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i),
        .wb_index_o(wb_index_o), .wb_way_o(wb_way_o), .wb_done_i(wb_done_i)
    );

    // tag array answers a granted read one cycle later; writeback completes one cycle after its grant
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arr_rvalid_i <= 1'b0;
            arr_valid_i  <= '0;
            arr_dirty_i  <= '0;
            arr_tag_i    <= '0;
            wb_done_i    <= 1'b0;
            wb_pend      <= 1'b0;
        end else begin
            arr_rvalid_i <= arr_req_o && arr_gnt_i && !arr_we_o;
            if (arr_req_o && arr_gnt_i && !arr_we_o) begin
                lk_cnt++;
                arr_valid_i <= val_m[arr_index_o];
                arr_dirty_i <= dirty_m[arr_index_o];
                arr_tag_i   <= tag_m[arr_index_o];
            end
            if (arr_req_o && arr_gnt_i && arr_we_o) begin
                inv_cnt++;
                inv_mask = arr_way_mask_o;
                val_m[arr_index_o] = val_m[arr_index_o] & ~arr_way_mask_o;
            end
            wb_done_i <= 1'b0;
            if (wb_pend && !wb_hold) begin
                wb_done_i <= 1'b1;
                wb_pend   <= 1'b0;
                dirty_m[wb_idx][wb_way] = 1'b0;
            end
            if (wb_req_o && wb_gnt_i) begin
                wb_cnt++;
                wb_idx = wb_index_o;
                wb_way = wb_way_o;
                wb_pend <= 1'b1;
            end
            if (cmo_resp_o.ack) ack_cnt++;
        end
    end

    task automatic clear_model();
        for (int s = 0; s < NR_SETS; s++) begin
            val_m[s] = '0;
            dirty_m[s] = '0;
            tag_m[s] = '0;
        end
    endtask

    // cyc is the cycle of ack counted from acceptance (0 = no ack within budget)
    task automatic send(input cmo_t op, input logic [63:0] addr, input logic [2:0] id,
                        output int cyc, output logic [2:0] rid, output logic rdy_before,
                        output logic ack_after, output logic rdy_after);
        @(negedge clk_i);
        rdy_before = cmo_resp_o.req_ready;
        cmo_req_i = '{1'b1, id, addr, op};
        @(posedge clk_i); #1;
        cmo_req_i = '{1'b0, ~id, ~addr, CMO_INVAL};
        cyc = 0;
        rid = '0;
        for (int k = 1; k <= 5000 && cyc == 0; k++) begin
            if (cmo_resp_o.ack) begin
                cyc = k;
                rid = cmo_resp_o.trans_id;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        @(posedge clk_i); #1;
        ack_after = cmo_resp_o.ack;
        rdy_after = cmo_resp_o.req_ready;
    endtask

    task automatic test_reset();
        logic [29:0] ov;
        rst_ni = 1'b0;
        gnt_en = 1'b1;
        wbg_en = 1'b1;
        wb_hold = 1'b0;
        cmo_req_i = '0;
        clear_model();
        repeat (3) @(negedge clk_i);
        ov = {cmo_resp_o.req_ready, cmo_resp_o.ack, cmo_resp_o.trans_id, arr_req_o, arr_we_o,
              arr_way_mask_o, wb_req_o, arr_index_o, wb_index_o, wb_way_o};
        checks++;
        if (ov !== 30'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", ov); end
        rst_ni = 1'b1;
        #1;
        checks++;
        if (cmo_resp_o.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", cmo_resp_o.req_ready); end
        checks++;
        if ({cmo_resp_o.ack, arr_req_o, wb_req_o} !== 3'b000) begin errors++; $display("FAIL reset_idle_quiet: got %b want 000", {cmo_resp_o.ack, arr_req_o, wb_req_o}); end
    endtask

    task automatic test_prefetch_w();
        int cyc, lk0 = lk_cnt;
        logic [2:0] rid;
        logic rb, aa, ra;
        send(CMO_PREFETCH_W, 64'h8000_1230, 3'd7, cyc, rid, rb, aa, ra);
        checks++;
        if (rb !== 1'b1) begin errors++; $display("FAIL pfw_ready: got %b want 1", rb); end
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL pfw_ack_cycle: got %0d want 1", cyc); end
        checks++;
        if (rid !== 3'd7) begin errors++; $display("FAIL pfw_trans_id: got %0d want 7", rid); end
        checks++;
        if (lk_cnt - lk0 !== 0) begin errors++; $display("FAIL pfw_no_lookup: got %0d want 0", lk_cnt - lk0); end
        checks++;
        if ({aa, ra} !== 2'b01) begin errors++; $display("FAIL pfw_ack_pulse: got ack=%b ready=%b want 0 1", aa, ra); end
    endtask

    task automatic test_clean_dirty();
        int cyc, lk0 = lk_cnt, wb0 = wb_cnt, inv0 = inv_cnt;
        logic [2:0] rid;
        logic rb, aa, ra;
        clear_model();
        val_m[8'h23] = 4'b0101;
        dirty_m[8'h23] = 4'b0101;
        tag_m[8'h23][0] = 44'h12345;
        tag_m[8'h23][2] = 44'h80001;
        send(CMO_CLEAN, 64'h8000_1230, 3'd5, cyc, rid, rb, aa, ra);
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL clean_ack_cycle: got %0d want 7", cyc); end
        checks++;
        if (rid !== 3'd5) begin errors++; $display("FAIL clean_trans_id: got %0d want 5", rid); end
        checks++;
        if (wb_cnt - wb0 !== 1) begin errors++; $display("FAIL clean_wb_count: got %0d want 1", wb_cnt - wb0); end
        checks++;
        if ({wb_idx, wb_way} !== {8'h23, 2'd2}) begin errors++; $display("FAIL clean_wb_target: got idx %h way %0d want idx 23 way 2", wb_idx, wb_way); end
        checks++;
        if (inv_cnt - inv0 !== 0) begin errors++; $display("FAIL clean_no_inval: got %0d want 0", inv_cnt - inv0); end
        checks++;
        if (lk_cnt - lk0 !== 1) begin errors++; $display("FAIL clean_lookups: got %0d want 1", lk_cnt - lk0); end
        checks++;
        if ({val_m[8'h23], dirty_m[8'h23]} !== 8'b0101_0001) begin errors++; $display("FAIL clean_line_state: got %b want 01010001", {val_m[8'h23], dirty_m[8'h23]}); end
    endtask

    task automatic test_inval_dirty();
        int cyc, wb0 = wb_cnt, inv0 = inv_cnt;
        logic [2:0] rid;
        logic rb, aa, ra;
        clear_model();
        val_m[8'h23] = 4'b0010;
        dirty_m[8'h23] = 4'b0010;
        tag_m[8'h23][1] = 44'h80001;
        send(CMO_INVAL, 64'h8000_1230, 3'd2, cyc, rid, rb, aa, ra);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL inval_ack_cycle: got %0d want 5", cyc); end
        checks++;
        if (rid !== 3'd2) begin errors++; $display("FAIL inval_trans_id: got %0d want 2", rid); end
        checks++;
        if (wb_cnt - wb0 !== 0) begin errors++; $display("FAIL inval_no_wb: got %0d want 0", wb_cnt - wb0); end
        checks++;
        if (inv_cnt - inv0 !== 1) begin errors++; $display("FAIL inval_count: got %0d want 1", inv_cnt - inv0); end
        checks++;
        if (inv_mask !== 4'b0010) begin errors++; $display("FAIL inval_mask: got %b want 0010", inv_mask); end
        checks++;
        if (val_m[8'h23] !== 4'b0000) begin errors++; $display("FAIL inval_valid_cleared: got %b want 0000", val_m[8'h23]); end
    endtask

    task automatic test_flush_miss();
        int cyc, wb0 = wb_cnt, inv0 = inv_cnt;
        logic [2:0] rid;
        logic rb, aa, ra;
        clear_model();
        dirty_m[8'h56] = 4'b1111;
        tag_m[8'h56] = {4{44'h4}};
        send(CMO_FLUSH, 64'h0000_4560, 3'd1, cyc, rid, rb, aa, ra);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL flush_miss_ack_cycle: got %0d want 4", cyc); end
        checks++;
        if ({wb_cnt - wb0, inv_cnt - inv0} !== {32'd0, 32'd0}) begin errors++; $display("FAIL flush_miss_activity: got wb %0d inval %0d want 0 0", wb_cnt - wb0, inv_cnt - inv0); end
        val_m[8'h56] = 4'b1000;
        dirty_m[8'h56] = 4'b0000;
        send(CMO_CLEAN, 64'h0000_4560, 3'd4, cyc, rid, rb, aa, ra);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL clean_nondirty_ack_cycle: got %0d want 4", cyc); end
        checks++;
        if ({wb_cnt - wb0, inv_cnt - inv0} !== {32'd0, 32'd0}) begin errors++; $display("FAIL clean_nondirty_activity: got wb %0d inval %0d want 0 0", wb_cnt - wb0, inv_cnt - inv0); end
    endtask

    task automatic test_flush_all();
        int cyc, lk0 = lk_cnt, wb0 = wb_cnt, inv0 = inv_cnt, ack0 = ack_cnt;
        logic [2:0] rid;
        logic rb, aa, ra;
        clear_model();
        val_m[0] = 4'b1001;
        dirty_m[0] = 4'b1001;
        tag_m[0] = {44'h111, 44'h0, 44'h0, 44'h222};
        val_m[255] = 4'b1001;
        dirty_m[255] = 4'b1001;
        tag_m[255] = {44'h333, 44'h0, 44'h0, 44'h444};
        send(CMO_FLUSH_ALL, 64'h0, 3'd3, cyc, rid, rb, aa, ra);
        checks++;
        if (rid !== 3'd3) begin errors++; $display("FAIL flush_all_trans_id: got %0d want 3", rid); end
        checks++;
        if (ack_cnt - ack0 !== 1) begin errors++; $display("FAIL flush_all_single_ack: got %0d want 1", ack_cnt - ack0); end
`ifdef DCACHE_CMO_ALL_EN
        checks++;
        if (lk_cnt - lk0 !== 256) begin errors++; $display("FAIL flush_all_lookups: got %0d want 256", lk_cnt - lk0); end
        checks++;
        if (wb_cnt - wb0 !== 4) begin errors++; $display("FAIL flush_all_wb_count: got %0d want 4", wb_cnt - wb0); end
        checks++;
        if (inv_cnt - inv0 !== 2) begin errors++; $display("FAIL flush_all_inval_count: got %0d want 2", inv_cnt - inv0); end
        checks++;
        if (inv_mask !== 4'b1001) begin errors++; $display("FAIL flush_all_inval_mask: got %b want 1001", inv_mask); end
        checks++;
        if ({wb_idx, wb_way} !== {8'hff, 2'd3}) begin errors++; $display("FAIL flush_all_last_wb: got idx %h way %0d want idx ff way 3", wb_idx, wb_way); end
        checks++;
        if ({val_m[0], dirty_m[0], val_m[255], dirty_m[255]} !== 16'h0) begin errors++; $display("FAIL flush_all_lines_cleared: got %h want 0", {val_m[0], dirty_m[0], val_m[255], dirty_m[255]}); end
`else
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL flush_all_ack_cycle: got %0d want 1", cyc); end
        checks++;
        if ({lk_cnt - lk0, wb_cnt - wb0, inv_cnt - inv0} !== {32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL flush_all_no_activity: got lk %0d wb %0d inval %0d want 0 0 0", lk_cnt - lk0, wb_cnt - wb0, inv_cnt - inv0); end
`endif
    endtask

    task automatic test_stall();
        int ack0 = ack_cnt;
        logic [29:0] ov;
        clear_model();
        val_m[8'h23] = 4'b0100;
        dirty_m[8'h23] = 4'b0100;
        tag_m[8'h23][2] = 44'h80001;
        gnt_en = 1'b0;
        wbg_en = 1'b0;
        wb_hold = 1'b1;
        @(negedge clk_i);
        cmo_req_i = '{1'b1, 3'd6, 64'h8000_1230, CMO_CLEAN};
        @(posedge clk_i); #1;
        cmo_req_i.req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({arr_req_o, arr_we_o, arr_index_o} !== {2'b10, 8'h23}) begin errors++; $display("FAIL stall_arr_hold c%0d: got %b %h want 10 23", k, {arr_req_o, arr_we_o}, arr_index_o); end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        gnt_en = 1'b1;
        for (int k = 0; k < 20 && !wb_req_o; k++) begin @(posedge clk_i); #1; end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({wb_req_o, wb_index_o, wb_way_o} !== {1'b1, 8'h23, 2'd2}) begin errors++; $display("FAIL stall_wb_hold c%0d: got %b %h %0d want 1 23 2", k, wb_req_o, wb_index_o, wb_way_o); end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        wbg_en = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if ({wb_req_o, cmo_resp_o.ack} !== 2'b00) begin errors++; $display("FAIL stall_wb_wait: got %b want 00", {wb_req_o, cmo_resp_o.ack}); end
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        ov = {cmo_resp_o.req_ready, cmo_resp_o.ack, cmo_resp_o.trans_id, arr_req_o, arr_we_o,
              arr_way_mask_o, wb_req_o, arr_index_o, wb_index_o, wb_way_o};
        checks++;
        if (ov !== 30'h0) begin errors++; $display("FAIL midop_reset_outputs: got %h want 0", ov); end
        checks++;
        if (ack_cnt - ack0 !== 0) begin errors++; $display("FAIL midop_no_ack: got %0d want 0", ack_cnt - ack0); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (cmo_resp_o.req_ready !== 1'b1) begin errors++; $display("FAIL midop_ready_after: got %b want 1", cmo_resp_o.req_ready); end
        wb_hold = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [2:0] rid;
        logic rb, aa, ra;
        cmo_t ops [3] = '{CMO_PREFETCH_R, CMO_ZERO, CMO_NONE};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 64'h1000_0040, 3'(i + 1), cyc, rid, rb, aa, ra);
            checks++;
            if ({rb, cyc[3:0], rid} !== {1'b1, 4'd1, 3'(i + 1)}) begin errors++; $display("FAIL b2b_%0d: got ready %b cycle %0d id %0d want 1 1 %0d", i, rb, cyc, rid, i + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_prefetch_w();
        test_clean_dirty();
        test_inval_dirty();
        test_flush_miss();
        test_flush_all();
        test_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
